sysid_boot_checker: RTL

- Avalon-MM read master that sequences the system-ID slave after reset and on demand.
- Reads the ID word (address 0), then the timestamp word (address 1), and compares each against parameterised expected values.
- Publishes done/pass/fail status and the captured words to the bring-up logic, which gates software release on a pass.
- Retries a read that gets no data within a bounded time, and reports a timeout if retries run out.

---
 rtl/sysid_boot_checker_if.sv | 18 +
 rtl/sysid_boot_checker.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only bus between the boot checker (master) and the system-ID slave.
interface sysid_boot_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sysid_boot_checker.sv
// Reads system-ID words 0 (ID) and 1 (timestamp) after reset or on start, compares them
// against expected values, and reports done/pass/timeout to bring-up logic.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h6236_4A88,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RETRY_MAX      = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  sysid_boot_checker_if.master       avm,
  output logic                       busy,
  output logic                       check_done,
  output logic                       id_ok,
  output logic                       ts_ok,
  output logic                       timeout_err,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value
);

  localparam logic [15:0] TMO_LOAD  = 16'(TIMEOUT_CYCLES);
  localparam logic [2:0]  RETRY_LIM = 3'(RETRY_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID_REQ,
    RD_ID_WAIT,
    RD_TS_REQ,
    RD_TS_WAIT,
    DONE
  } state_t;

  state_t      state;
  logic        auto_start;
  logic [15:0] tmo_cnt;
  logic [2:0]  retry_cnt;

  // auto_start makes the first clock out of reset behave like a start pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      auto_start      <= 1'b1;
      tmo_cnt         <= '0;
      retry_cnt       <= '0;
      busy            <= 1'b0;
      check_done      <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout_err     <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start || auto_start) begin
            auto_start      <= 1'b0;
            check_done      <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout_err     <= 1'b0;
            retry_cnt       <= '0;
            busy            <= 1'b1;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= 1'b0;
            state           <= RD_ID_REQ;
          end
        end

        RD_ID_REQ, RD_TS_REQ: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            tmo_cnt      <= TMO_LOAD;
            state        <= (state == RD_ID_REQ) ? RD_ID_WAIT : RD_TS_WAIT;
          end
        end

        RD_ID_WAIT, RD_TS_WAIT: begin
          // Data arriving on the last timeout cycle takes priority over retry/timeout.
          if (avm.avm_readdatavalid) begin
            if (state == RD_ID_WAIT) begin
              id_value        <= avm.avm_readdata;
              id_ok           <= (avm.avm_readdata == EXPECTED_ID);
              retry_cnt       <= '0;
              avm.avm_read    <= 1'b1;
              avm.avm_address <= 1'b1;
              state           <= RD_TS_REQ;
            end else begin
              ts_value   <= avm.avm_readdata;
              ts_ok      <= (avm.avm_readdata == EXPECTED_TS);
              busy       <= 1'b0;
              check_done <= 1'b1;
              state      <= DONE;
            end
          end else if (tmo_cnt == 16'd1) begin
            if (retry_cnt < RETRY_LIM) begin
              retry_cnt    <= retry_cnt + 3'd1;
              avm.avm_read <= 1'b1;
              state        <= (state == RD_ID_WAIT) ? RD_ID_REQ : RD_TS_REQ;
            end else begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              check_done  <= 1'b1;
              state       <= DONE;
            end
          end else begin
            tmo_cnt <= tmo_cnt - 16'd1;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          avm.avm_read <= 1'b0;
        end
      endcase
    end
  end

endmodule
